// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 Set-2 decoder slice.
//   - prefix bytes (E0 extended, F0 break, E1 pause sequence)
//   - modifier keycodes
//   - decoder FSM state enum and modifier state struct
//   - is_ignored(): protocol/acknowledge bytes that never form an event
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    localparam logic [7:0] SC_SHIFT_L = 8'h12;
    localparam logic [7:0] SC_SHIFT_R = 8'h59;
    localparam logic [7:0] SC_CTRL    = 8'h14;  // E0-prefixed = right ctrl
    localparam logic [7:0] SC_ALT     = 8'h11;  // E0-prefixed = right alt
    localparam logic [7:0] SC_CAPS    = 8'h58;

    // Bytes that follow E1 before the Pause key sequence is complete.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } decoder_state_t;

    typedef struct packed {
        logic caps_lock;
        logic alt;
        logic ctrl;
        logic shift;
    } mods_t;

    function automatic logic is_ignored(input logic [7:0] code);
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ignored = 1'b1;
            default:                    is_ignored = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// scancode_to_ascii: combinational Set-2 keycode to ASCII lookup (US layout).
// Ports:
//   keycode_in  8  final byte of the key event
//   extended_in 1  key was E0-prefixed
//   shift_in    1  either shift held
//   caps_in     1  caps lock active (letters only)
//   ctrl_in     1  either ctrl held (letters map to control codes)
//   ascii_out   8  character, 0 when the key has no character
module scancode_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] keycode_in,
    input  logic       extended_in,
    input  logic       shift_in,
    input  logic       caps_in,
    input  logic       ctrl_in,
    output logic [7:0] ascii_out
);

    logic [7:0] lower;      // lowercase letter, 0 if not a letter
    logic [7:0] plain;      // unshifted digit/punctuation/fixed code
    logic [7:0] shifted;    // shifted digit/punctuation
    logic [7:0] upper;

    always_comb begin
        lower = 8'h00;
        case (keycode_in)
            8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";
            8'h23: lower = "d";  8'h24: lower = "e";  8'h2B: lower = "f";
            8'h34: lower = "g";  8'h33: lower = "h";  8'h43: lower = "i";
            8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
            8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";
            8'h4D: lower = "p";  8'h15: lower = "q";  8'h2D: lower = "r";
            8'h1B: lower = "s";  8'h2C: lower = "t";  8'h3C: lower = "u";
            8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
            8'h35: lower = "y";  8'h1A: lower = "z";
            default: lower = 8'h00;
        endcase
    end

    always_comb begin
        plain   = 8'h00;
        shifted = 8'h00;
        case (keycode_in)
            8'h45: begin plain = "0";  shifted = ")"; end
            8'h16: begin plain = "1";  shifted = "!"; end
            8'h1E: begin plain = "2";  shifted = "@"; end
            8'h26: begin plain = "3";  shifted = "#"; end
            8'h25: begin plain = "4";  shifted = "$"; end
            8'h2E: begin plain = "5";  shifted = "%"; end
            8'h36: begin plain = "6";  shifted = "^"; end
            8'h3D: begin plain = "7";  shifted = "&"; end
            8'h3E: begin plain = "8";  shifted = "*"; end
            8'h46: begin plain = "9";  shifted = "("; end
            8'h0E: begin plain = 8'h60; shifted = "~"; end
            8'h4E: begin plain = "-";  shifted = "_"; end
            8'h55: begin plain = "=";  shifted = "+"; end
            8'h54: begin plain = "[";  shifted = "{"; end
            8'h5B: begin plain = "]";  shifted = "}"; end
            8'h5D: begin plain = "\\"; shifted = "|"; end
            8'h4C: begin plain = ";";  shifted = ":"; end
            8'h52: begin plain = "'";  shifted = "\""; end
            8'h41: begin plain = ",";  shifted = "<"; end
            8'h49: begin plain = ".";  shifted = ">"; end
            8'h4A: begin plain = "/";  shifted = "?"; end
            // Whitespace/control keys are unaffected by shift.
            8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
            8'h66: begin plain = 8'h08; shifted = 8'h08; end
            8'h0D: begin plain = 8'h09; shifted = 8'h09; end
            8'h29: begin plain = 8'h20; shifted = 8'h20; end
            8'h76: begin plain = 8'h1B; shifted = 8'h1B; end
            default: begin plain = 8'h00; shifted = 8'h00; end
        endcase
    end

    assign upper = lower - 8'h20;

    always_comb begin
        ascii_out = 8'h00;
        if (extended_in) begin
            // Only keypad Enter and keypad slash carry a character.
            case (keycode_in)
                8'h5A:   ascii_out = 8'h0D;
                8'h4A:   ascii_out = "/";
                default: ascii_out = 8'h00;
            endcase
        end else if (lower != 8'h00) begin
            if (ctrl_in)
                ascii_out = upper & 8'h1F;
            else if (shift_in ^ caps_in)
                ascii_out = upper;
            else
                ascii_out = lower;
        end else begin
            ascii_out = shift_in ? shifted : plain;
        end
    end

endmodule

// File: rtl/ps2_decoder.sv
// ps2_decoder: assembles PS/2 Set-2 bytes into key events and characters.
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   scancode_in/valid_in    received byte and its one-cycle strobe
//   error_in                framing/parity error strobe, aborts any prefix
//   event_valid_out         one-cycle strobe per complete key event
//   make_out/extended_out   press(1)/release(0), E0-prefixed flag
//   keycode_out             final byte of the event
//   char_valid_out/ascii_out character strobe and value
//   mods_out                {caps_lock, alt, ctrl, shift}
module ps2_decoder
    import ps2_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] scancode_in,
    input  logic       valid_in,
    input  logic       error_in,
    output logic       event_valid_out,
    output logic       make_out,
    output logic       extended_out,
    output logic [7:0] keycode_out,
    output logic       char_valid_out,
    output logic [7:0] ascii_out,
    output logic [3:0] mods_out
);

    decoder_state_t state_q, state_d;
    logic [2:0]     skip_q, skip_d;

    logic ev_fire, ev_make, ev_ext;

    logic lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q, caps_q, caps_held_q;
    logic lshift_d, rshift_d, lctrl_d, rctrl_d, lalt_d, ralt_d, caps_d, caps_held_d;

    mods_t      mods_q, mods_d;
    logic       is_mod_key;
    logic [7:0] lut_ascii;

    logic       event_valid_q, make_q, ext_q, char_valid_q;
    logic [7:0] keycode_q, ascii_q;

    function automatic logic is_fake_shift(input logic [7:0] code);
        is_fake_shift = (code == SC_SHIFT_L) || (code == SC_SHIFT_R);
    endfunction

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            skip_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        ev_fire = 1'b0;
        ev_make = 1'b0;
        ev_ext  = 1'b0;
        if (error_in) begin
            // An error also swallows a byte arriving in the same cycle.
            state_d = ST_IDLE;
            skip_d  = 3'd0;
        end else if (valid_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (scancode_in == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (scancode_in == SC_BRK) begin
                        state_d = ST_BRK;
                    end else if (scancode_in == SC_PAUSE) begin
                        state_d = ST_PAUSE;
                        skip_d  = PAUSE_SKIP;
                    end else if (!is_ignored(scancode_in)) begin
                        ev_fire = 1'b1;
                        ev_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (scancode_in == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        // E0 12 / E0 59 are synthetic shifts around nav keys.
                        if (!is_fake_shift(scancode_in)) begin
                            ev_fire = 1'b1;
                            ev_make = 1'b1;
                            ev_ext  = 1'b1;
                        end
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    ev_fire = 1'b1;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    if (!is_fake_shift(scancode_in)) begin
                        ev_fire = 1'b1;
                        ev_ext  = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (skip_q <= 3'd1) begin
                        state_d = ST_IDLE;
                        skip_d  = 3'd0;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    skip_d  = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        lctrl_d     = lctrl_q;
        rctrl_d     = rctrl_q;
        lalt_d      = lalt_q;
        ralt_d      = ralt_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        is_mod_key  = 1'b0;
        if (!ev_ext) begin
            case (scancode_in)
                SC_SHIFT_L, SC_SHIFT_R, SC_CTRL, SC_ALT, SC_CAPS: is_mod_key = 1'b1;
                default: is_mod_key = 1'b0;
            endcase
        end else begin
            is_mod_key = (scancode_in == SC_CTRL) || (scancode_in == SC_ALT);
        end
        if (ev_fire) begin
            if (!ev_ext) begin
                case (scancode_in)
                    SC_SHIFT_L: lshift_d = ev_make;
                    SC_SHIFT_R: rshift_d = ev_make;
                    SC_CTRL:    lctrl_d  = ev_make;
                    SC_ALT:     lalt_d   = ev_make;
                    SC_CAPS: begin
                        // Typematic repeats keep caps_held set and do not re-toggle.
                        if (ev_make && !caps_held_q)
                            caps_d = ~caps_q;
                        caps_held_d = ev_make;
                    end
                    default: ;
                endcase
            end else begin
                case (scancode_in)
                    SC_CTRL: rctrl_d = ev_make;
                    SC_ALT:  ralt_d  = ev_make;
                    default: ;
                endcase
            end
        end
    end

    assign mods_d = '{caps_lock: caps_d,
                      alt:       lalt_d | ralt_d,
                      ctrl:      lctrl_d | rctrl_d,
                      shift:     lshift_d | rshift_d};

    scancode_to_ascii u_lut (
        .keycode_in  (scancode_in),
        .extended_in (ev_ext),
        .shift_in    (mods_q.shift),
        .caps_in     (mods_q.caps_lock),
        .ctrl_in     (mods_q.ctrl),
        .ascii_out   (lut_ascii)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            lshift_q      <= 1'b0;
            rshift_q      <= 1'b0;
            lctrl_q       <= 1'b0;
            rctrl_q       <= 1'b0;
            lalt_q        <= 1'b0;
            ralt_q        <= 1'b0;
            caps_q        <= 1'b0;
            caps_held_q   <= 1'b0;
            mods_q        <= '0;
            event_valid_q <= 1'b0;
            char_valid_q  <= 1'b0;
            make_q        <= 1'b0;
            ext_q         <= 1'b0;
            keycode_q     <= 8'h00;
            ascii_q       <= 8'h00;
        end else begin
            lshift_q      <= lshift_d;
            rshift_q      <= rshift_d;
            lctrl_q       <= lctrl_d;
            rctrl_q       <= rctrl_d;
            lalt_q        <= lalt_d;
            ralt_q        <= ralt_d;
            caps_q        <= caps_d;
            caps_held_q   <= caps_held_d;
            mods_q        <= mods_d;
            event_valid_q <= ev_fire;
            char_valid_q  <= ev_fire && ev_make && !is_mod_key && (lut_ascii != 8'h00);
            if (ev_fire) begin
                make_q    <= ev_make;
                ext_q     <= ev_ext;
                keycode_q <= scancode_in;
            end
            if (ev_fire && ev_make && !is_mod_key && (lut_ascii != 8'h00))
                ascii_q <= lut_ascii;
        end
    end

    assign event_valid_out = event_valid_q;
    assign char_valid_out  = char_valid_q;
    assign make_out        = make_q;
    assign extended_out    = ext_q;
    assign keycode_out     = keycode_q;
    assign ascii_out       = ascii_q;
    assign mods_out        = mods_q;

endmodule
